// File: rtl/truth_table_tester.sv
// truth_table_tester
//
// Stimulus and compare engine for a small N-input, 1-output combinational
// device. On start it walks vec through 0 .. 2^N-1, holds each vector for HOLD
// cycles and, on the last hold cycle, compares dut_y against TRUTH[vec].
// Failing compares pulse mismatch, bump err_count and the first failing
// vector is latched in first_fail. done/pass stay up until the next start
// or reset.
//
// Parameters:
//   N      number of device inputs (1..8)
//   TRUTH  expected output per vector, bit i for vec == i (2^N bits)
//   HOLD   cycles each vector is held (>= 1)
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high; clears all state
//   start       in   begin a sweep; only honoured while idle or done
//   dut_y       in   device output, sampled on the compare cycle
//   vec         out  [N-1:0] vector driven to the device inputs
//   busy        out  sweep in progress
//   done        out  sweep complete, held until start/reset
//   pass        out  done with zero mismatches
//   mismatch    out  one-cycle pulse after each failing compare
//   err_count   out  [N:0] number of mismatches (0..2^N)
//   first_fail  out  [N-1:0] vector of the first mismatch
module truth_table_tester #(
  parameter int                N     = 3,
  parameter logic [(1<<N)-1:0] TRUTH = 8'h31,
  parameter int                HOLD  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dut_y,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         mismatch,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail
);

  // hold_cnt needs at least one bit even when HOLD == 1
  localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [N-1:0]  VEC_LAST  = '1;
  localparam logic [N-1:0]  VEC_ONE   = N'(1);
  localparam logic [N:0]    ERR_ONE   = (N+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic          cmp_cycle;
  logic          cmp_fail;

  assign cmp_cycle = (state == S_APPLY) && (hold_cnt == HOLD_LAST);
  assign cmp_fail  = cmp_cycle && (dut_y != TRUTH[vec]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      vec        <= '0;
      mismatch   <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_APPLY;
            hold_cnt   <= '0;
            vec        <= '0;
            err_count  <= '0;
            first_fail <= '0;
          end
        end
        S_APPLY: begin
          if (cmp_cycle) begin
            if (cmp_fail) begin
              mismatch  <= 1'b1;
              err_count <= err_count + ERR_ONE;
              // err_count still holds the pre-increment value here
              if (err_count == '0) first_fail <= vec;
            end
            hold_cnt <= '0;
            // equality test on the last vector, so vec never wraps
            if (vec == VEC_LAST) state <= S_DONE;
            else                 vec   <= vec + VEC_ONE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // status flags decoded from registered state only, so pass cannot
  // rise while a sweep is running
  assign busy = (state == S_APPLY);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_tester.sv
// Bench for truth_table_tester: three instances (N=3/HOLD=2, N=3/HOLD=1,
// N=4/HOLD=2) share clock and reset. A sweep-level reference model tracks
// elapsed cycles since start and derives vec, flags and error statistics from
// that count with plain division; every cycle all outputs are compared.
module tb_truth_table_tester;

  logic clk = 1'b0;
  logic reset;
  logic start_a [3];
  logic y_a     [3];

  logic [2:0] vec0, ff0;
  logic [3:0] err0;
  logic [2:0] vec1, ff1;
  logic [3:0] err1;
  logic [3:0] vec2, ff2;
  logic [4:0] err2;

  logic busy_a [3];
  logic done_a [3];
  logic pass_a [3];
  logic mis_a  [3];
  logic [8:0] vec_a [3];
  logic [8:0] err_a [3];
  logic [8:0] ff_a  [3];

  always #5 clk = ~clk;

  truth_table_tester #(.N(3), .TRUTH(8'h31), .HOLD(2)) d0 (
    .clk(clk), .reset(reset), .start(start_a[0]), .dut_y(y_a[0]),
    .vec(vec0), .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]),
    .mismatch(mis_a[0]), .err_count(err0), .first_fail(ff0));

  truth_table_tester #(.N(3), .TRUTH(8'h31), .HOLD(1)) d1 (
    .clk(clk), .reset(reset), .start(start_a[1]), .dut_y(y_a[1]),
    .vec(vec1), .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]),
    .mismatch(mis_a[1]), .err_count(err1), .first_fail(ff1));

  truth_table_tester #(.N(4), .TRUTH(16'h8001), .HOLD(2)) d2 (
    .clk(clk), .reset(reset), .start(start_a[2]), .dut_y(y_a[2]),
    .vec(vec2), .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]),
    .mismatch(mis_a[2]), .err_count(err2), .first_fail(ff2));

  assign vec_a[0] = 9'(vec0); assign err_a[0] = 9'(err0); assign ff_a[0] = 9'(ff0);
  assign vec_a[1] = 9'(vec1); assign err_a[1] = 9'(err1); assign ff_a[1] = 9'(ff1);
  assign vec_a[2] = 9'(vec2); assign err_a[2] = 9'(err2); assign ff_a[2] = 9'(ff2);

  // instance configuration
  int         NN [3] = '{3, 3, 4};
  int         HH [3] = '{2, 1, 2};
  logic [15:0] TT [3] = '{16'h0031, 16'h0031, 16'h8001};

  // reference model: sweep running, cycles elapsed in sweep, errors, first
  // failing vector, sweep finished, mismatch pulse
  bit m_act [3];
  int m_cyc [3];
  int m_err [3];
  int m_ff  [3];
  bit m_dn  [3];
  bit m_mis [3];

  // dut_y modes: 0 correct, 1 stuck 0, 2 inverted, 3 wrong at vector 15 only,
  // 4 random
  int mode [3];
  bit rnd  [3];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // vector the device should currently be seeing
  function automatic int exp_vec(input int i);
    if (m_act[i])     return m_cyc[i] / HH[i];
    else if (m_dn[i]) return (1 << NN[i]) - 1;
    else              return 0;
  endfunction

  // device stand-in driven from the model's view of the current vector
  always_comb begin
    int   v;
    logic e;
    v = 0;
    e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = m_act[i] ? (m_cyc[i] / HH[i]) : (m_dn[i] ? ((1 << NN[i]) - 1) : 0);
      e = TT[i][v];
      case (mode[i])
        0:       y_a[i] = e;
        1:       y_a[i] = 1'b0;
        2:       y_a[i] = ~e;
        3:       y_a[i] = e ^ (v == 15);
        default: y_a[i] = rnd[i];
      endcase
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) rnd[i] = 1'($urandom);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_act[i] <= 1'b0; m_cyc[i] <= 0; m_err[i] <= 0;
        m_ff[i]  <= 0;    m_dn[i]  <= 1'b0; m_mis[i] <= 1'b0;
      end else begin
        m_mis[i] <= 1'b0;
        if (m_act[i]) begin
          // last cycle of a vector's hold period is the compare cycle
          if ((m_cyc[i] % HH[i]) == HH[i] - 1 &&
              y_a[i] != TT[i][m_cyc[i] / HH[i]]) begin
            m_err[i] <= m_err[i] + 1;
            m_mis[i] <= 1'b1;
            if (m_err[i] == 0) m_ff[i] <= m_cyc[i] / HH[i];
          end
          m_cyc[i] <= m_cyc[i] + 1;
          if (m_cyc[i] + 1 == (1 << NN[i]) * HH[i]) begin
            m_act[i] <= 1'b0;
            m_dn[i]  <= 1'b1;
          end
        end else if (start_a[i]) begin
          m_act[i] <= 1'b1; m_cyc[i] <= 0; m_err[i] <= 0;
          m_ff[i]  <= 0;    m_dn[i]  <= 1'b0;
        end
      end
    end
  end

  // per-cycle compare of every output of every instance
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("d%0d vec", i),  int'(vec_a[i]), exp_vec(i));
        chk($sformatf("d%0d busy", i), int'(busy_a[i]), int'(m_act[i]));
        chk($sformatf("d%0d done", i), int'(done_a[i]), int'(m_dn[i]));
        chk($sformatf("d%0d pass", i), int'(pass_a[i]), int'(m_dn[i] && m_err[i] == 0));
        chk($sformatf("d%0d mismatch", i), int'(mis_a[i]), int'(m_mis[i]));
        chk($sformatf("d%0d err_count", i), int'(err_a[i]), m_err[i]);
        chk($sformatf("d%0d first_fail", i), int'(ff_a[i]), m_ff[i]);
      end
    end
  end

  // Runs one sweep on instance i. Cycle c=1 is the first cycle after the
  // start edge. pc: cycle in which to pulse start again (ignored if <1).
  task automatic sweep(input int i, input int md, input int pc,
                       output int nb, output int dc, output int nm, output int e1);
    mode[i] = md;
    @(negedge clk);
    start_a[i] = 1'b1;
    @(negedge clk);
    start_a[i] = 1'b0;
    nb = 0; nm = 0; dc = -1; e1 = -1;
    for (int c = 1; c < 400 && dc < 0; c++) begin
      if (c == 1) e1 = int'(err_a[i]);
      nb += int'(busy_a[i]);
      nm += int'(mis_a[i]);
      if (done_a[i]) dc = c;
      else begin
        start_a[i] = (c == pc);
        @(negedge clk);
      end
    end
    start_a[i] = 1'b0;
    if (dc < 0) chk($sformatf("d%0d sweep timeout", i), 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, dc, nm, e1;
    int ri, rm, rp;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      mode[i]    = 0;
    end
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("reset vec", int'(vec_a[i]), 0);
      chk("reset busy", int'(busy_a[i]), 0);
      chk("reset done", int'(done_a[i]), 0);
      chk("reset err", int'(err_a[i]), 0);
    end

    // correct device: 16 busy cycles, done in cycle 17, pass
    sweep(0, 0, -1, nb, dc, nm, e1);
    chk("t1 busy cycles", nb, 16);
    chk("t1 done cycle", dc, 17);
    chk("t1 pass", int'(pass_a[0]), 1);
    chk("t1 err", int'(err_a[0]), 0);

    // stuck-at-0 device: fails at vectors 0, 4, 5
    sweep(0, 1, -1, nb, dc, nm, e1);
    chk("t2 err", int'(err_a[0]), 3);
    chk("t2 first_fail", int'(ff_a[0]), 0);
    chk("t2 pulses", nm, 3);
    chk("t2 pass", int'(pass_a[0]), 0);

    // inverted device, both hold lengths
    sweep(0, 2, -1, nb, dc, nm, e1);
    chk("t3 err", int'(err_a[0]), 8);
    chk("t3 first_fail", int'(ff_a[0]), 0);
    chk("t3 pass", int'(pass_a[0]), 0);
    sweep(1, 2, -1, nb, dc, nm, e1);
    chk("t3 hold1 busy", nb, 8);
    chk("t3 hold1 done cycle", dc, 9);
    chk("t3 hold1 err", int'(err_a[1]), 8);

    // start while vec == 3 is ignored; restart from DONE clears errors
    sweep(0, 0, 7, nb, dc, nm, e1);
    chk("t4 done cycle", dc, 17);
    chk("t4 busy cycles", nb, 16);
    sweep(0, 1, -1, nb, dc, nm, e1);
    chk("t4 err before restart", int'(err_a[0]), 3);
    sweep(0, 0, -1, nb, dc, nm, e1);
    chk("t4 err after restart", e1, 0);
    chk("t4 pass", int'(pass_a[0]), 1);

    // reset mid-sweep at vec 5 with two errors logged
    mode[0] = 1;
    @(negedge clk);
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5 vec before reset", int'(vec_a[0]), 5);
    chk("t5 err before reset", int'(err_a[0]), 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5 vec", int'(vec_a[0]), 0);
    chk("t5 busy", int'(busy_a[0]), 0);
    chk("t5 err", int'(err_a[0]), 0);
    chk("t5 first_fail", int'(ff_a[0]), 0);
    chk("t5 mismatch", int'(mis_a[0]), 0);
    sweep(0, 0, -1, nb, dc, nm, e1);
    chk("t5 resweep done cycle", dc, 17);
    chk("t5 resweep pass", int'(pass_a[0]), 1);

    // N=4: only vector 15 wrong
    sweep(2, 3, -1, nb, dc, nm, e1);
    chk("t6 err", int'(err_a[2]), 1);
    chk("t6 first_fail", int'(ff_a[2]), 15);
    chk("t6 busy cycles", nb, 32);
    chk("t6 done cycle", dc, 33);
    chk("t6 pulses", nm, 1);

    // randomized sweeps, checked cycle by cycle against the model
    repeat (10) begin
      ri = $urandom_range(0, 2);
      rm = $urandom_range(0, 4);
      rp = $urandom_range(0, 40);
      sweep(ri, rm, rp, nb, dc, nm, e1);
      chk("rand pulses vs err", nm, int'(err_a[ri]));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
